// File: rtl/pipe_reg_file_pkg.sv
// Shared types and default sizes for the pipelined register file.
package pipe_reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage : pipe_reg_file_pkg

// File: rtl/pipe_reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write.
module reg_scoreboard
  import pipe_reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              pend1_c,
  output logic              pend2_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Clear applied before set so a same-address issue keeps the bit high.
  always_comb begin
    pend_d = pend_q;
    if (en && clr_en) pend_d[clr_addr] = 1'b0;
    if (en && set_en) pend_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend1_c = en & pend_q[ra1];
  assign pend2_c = en & pend_q[ra2];

endmodule : reg_scoreboard

// File: rtl/pipe_reg_file.sv
// 2R1W register file with post-reset clear sweep and pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module pipe_reg_file
  import pipe_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              pend1,
  output logic              pend2,
  output logic              ready
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam bit                ZERO  = (ZERO_REG != 0);

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_ready;
  logic              wr_en;

  assign in_ready = (state == READY);
  assign wr_en    = in_ready && we && !(ZERO && (wa == '0));

  // Sweep FSM; the counter parks on the last entry until the next rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        READY: begin
          state <= READY;
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_en)     mem[wa]  <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    if (in_ready && !(ZERO && (ra1 == '0))) begin
      rd1 = mem[ra1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wa == ra1)) rd1 = wd;
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (in_ready && !(ZERO && (ra2 == '0))) begin
      rd2 = mem[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wa == ra2)) rd2 = wd;
`endif
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (in_ready),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (we),
    .clr_addr (wa),
    .ra1      (ra1),
    .ra2      (ra2),
    .pend1_c  (pend1),
    .pend2_c  (pend2)
  );

endmodule : pipe_reg_file

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file: default 32x32 instance plus an 8x16 instance.
module tb_pipe_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, iss_en, pend1, pend2, ready;
  logic [4:0]  ra1, ra2, wa, iss_addr;
  logic [31:0] rd1, rd2, wd;

  logic        s_rst, s_we, s_iss_en, s_pend1, s_pend2, s_ready;
  logic [2:0]  s_ra1, s_ra2, s_wa, s_iss_addr;
  logic [15:0] s_rd1, s_rd2, s_wd;

  pipe_reg_file dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend1(pend1), .pend2(pend2), .ready(ready)
  );

  pipe_reg_file #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .clk(clk), .rst(s_rst), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .we(s_we), .wa(s_wa), .wd(s_wd), .iss_en(s_iss_en), .iss_addr(s_iss_addr),
    .pend1(s_pend1), .pend2(s_pend2), .ready(s_ready)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_p1;
    logic        e_p2;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Expected outputs are those seen before the clock edge that applies the inputs.
    tbl[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  5'd5,  5'd1,  (BYP ? 32'hDEAD_BEEF : 32'h0), 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd0,  32'h1234_5678, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd7,  5'd5,  32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd7,  32'h0, 32'h0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 5'd7,  32'h0000_0777, 1'b1, 5'd7,  5'd7,  5'd3,  (BYP ? 32'h777 : 32'h0), 32'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd4,  32'h777, 32'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd7,  32'h0000_0888, 1'b0, 5'd0,  5'd7,  5'd7,  (BYP ? 32'h888 : 32'h777), (BYP ? 32'h888 : 32'h777), 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd3,  32'h888, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd10, 32'hA5A5_A5A5, 1'b1, 5'd9,  5'd9,  5'd10, 32'h0, (BYP ? 32'hA5A5_A5A5 : 32'h0), 1'b0, 1'b0};
    tbl[11] = '{1'b1, 5'd9,  32'h5A5A_5A5A, 1'b1, 5'd10, 5'd9,  5'd10, (BYP ? 32'h5A5A_5A5A : 32'h0), 32'hA5A5_A5A5, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd10, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 5'd9,  32'hFFFF_FFFF, 1'b0, 5'd0,  5'd31, 5'd9,  32'h0, 32'h5A5A_5A5A, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd31, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b0};

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss_en = 1'b0; iss_addr = '0; ra1 = '0; ra2 = '0;
    s_rst = 1'b1; s_we = 1'b0; s_wa = '0; s_wd = '0; s_iss_en = 1'b0; s_iss_addr = '0;
    s_ra1 = '0; s_ra2 = '0;

    @(negedge clk);
    cyc();
    check("reset ready", 32'(ready), 32'h0);
    check("reset pend1", 32'(pend1), 32'h0);

    // Sweep with writes and issues asserted; both must be ignored.
    rst = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hAAAA_AAAA; iss_en = 1'b1; iss_addr = 5'd3; ra1 = 5'd4;
    for (int i = 0; i < 32; i++) begin
      #1;
      check($sformatf("sweep%0d ready", i), 32'(ready), 32'h0);
      check($sformatf("sweep%0d rd1", i), rd1, 32'h0);
      cyc();
    end
    we = 1'b0; iss_en = 1'b0;
    #1;
    check("sweep done ready", 32'(ready), 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      iss_en = tbl[i].iss_en; iss_addr = tbl[i].iss_addr;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      #1;
      check($sformatf("v%0d rd1", i), rd1, tbl[i].e_rd1);
      check($sformatf("v%0d rd2", i), rd2, tbl[i].e_rd2);
      check($sformatf("v%0d pend1", i), 32'(pend1), 32'(tbl[i].e_p1));
      check($sformatf("v%0d pend2", i), 32'(pend2), 32'(tbl[i].e_p2));
      cyc();
    end

    // rst in READY drops the in-flight write and clears the scoreboard.
    rst = 1'b1; we = 1'b1; wa = 5'd12; wd = 32'hCCCC_CCCC; iss_en = 1'b0; ra1 = 5'd10; ra2 = 5'd9;
    cyc();
    we = 1'b0;
    #1;
    check("ready rst ready", 32'(ready), 32'h0);
    check("ready rst pend1", 32'(pend1), 32'h0);
    check("ready rst rd2", rd2, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      check($sformatf("resweep%0d ready", i), 32'(ready), 32'h0);
      cyc();
    end
    #1;
    check("resweep done ready", 32'(ready), 32'h1);
    ra1 = 5'd12; ra2 = 5'd5;
    #1;
    check("dropped write rd1", rd1, 32'h0);
    check("cleared entry5 rd2", rd2, 32'h0);
    ra1 = 5'd10; ra2 = 5'd9;
    #1;
    check("cleared pend10", 32'(pend1), 32'h0);
    check("cleared entry9 rd2", rd2, 32'h0);
    cyc();

    // Narrow instance: 8-entry sweep then a write to the top entry.
    s_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("small sweep%0d ready", i), 32'(s_ready), 32'h0);
      cyc();
    end
    #1;
    check("small ready", 32'(s_ready), 32'h1);
    s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF; s_ra1 = 3'd7; s_ra2 = 3'd6;
    #1;
    check("small same-cycle rd1", 32'(s_rd1), (BYP ? 32'hBEEF : 32'h0));
    cyc();
    s_we = 1'b0; s_ra2 = 3'd7;
    #1;
    check("small rd1", 32'(s_rd1), 32'hBEEF);
    check("small rd2", 32'(s_rd2), 32'hBEEF);
    check("small pend", 32'({s_pend1, s_pend2}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_reg_file
